// File: rtl/top.sv
// top: three-state one-hot FSM with a Mealy output.
// The state walks idle -> s0, then toggles s0 <-> s1 on every cycle where din=1.
// dout marks each s1 -> s0 transition cycle, so it is high whenever state is s1 and din is 1.
module top (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   // The encoding is fixed one-hot.
   // The names state, next_state, idle, s0 and s1 are kept stable so hierarchical probes can find them.
   typedef enum logic [2:0] {
      idle = 3'b001,
      s0   = 3'b010,
      s1   = 3'b100
   } state_t;

   state_t state;
   state_t next_state;

   // State register: asynchronous reset to idle, otherwise load next_state every rising edge.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= idle;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and Mealy output decode, purely combinational from state and din.
   // NOTE: defaults are assigned first so every path drives every output (no latches).
   always_comb begin
      next_state = idle;
      dout       = 1'b0;
      case (state)
         idle: next_state = s0;
         s0:   next_state = din ? s1 : s0;
         s1: begin
            next_state = din ? s0 : s1;
            dout       = din;
         end
         // Any corrupted or unreachable value recovers through idle.
         default: next_state = idle;
      endcase
   end

endmodule

// File: tb/tb_top.sv
// tb_top: self-checking bench for the one-hot FSM in top.
// The reference model tracks the position as a plain integer:
// 0 = idle, 1 = s0, 2 = s1.
// Expected one-hot codes are derived from that integer.
module tb_top;

   logic clk;
   logic rst;
   logic din;
   logic dout;

   int n_tests;
   int n_fail;
   int m;          // model position: 0 idle, 1 s0, 2 s1
   bit seen [3];

   top dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dout (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] enc(input int p);
      logic [2:0] one;
      one = 3'b001;
      return one << p;
   endfunction

   function automatic int model_next(input int p, input logic d);
      if (p == 0) return 1;
      if (d) return 3 - p;   // s0 and s1 swap
      return p;
   endfunction

   // Checks the state code and one-hotness of the current state.
   task automatic check_state(input string tag);
      logic [2:0] s;
      s = dut.state;
      check(tag, s, enc(m));
      check({tag, "_onehot"}, {2'b00, $onehot(s)}, 3'b001);
      if (s === enc(0)) seen[0] = 1'b1;
      if (s === enc(1)) seen[1] = 1'b1;
      if (s === enc(2)) seen[2] = 1'b1;
   endtask

   // One cycle: apply din, check the combinational dout, clock, then check the new state.
   task automatic step(input string tag, input logic d);
      din = d;
      #1;
      check({tag, "_dout"}, {2'b00, dout}, {2'b00, (m == 2) && d});
      @(posedge clk);
      m = model_next(m, d);
      #1;
      check_state(tag);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      m   = 0;
      #1;
      check_state("rst_async");
      check("rst_dout", {2'b00, dout}, 3'b000);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check_state("rst_hold");
         check("rst_hold_dout", {2'b00, dout}, 3'b000);
      end
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m       = 0;
      rst     = 1'b1;
      din     = 1'b0;
      #2;

      // Reset for three cycles with din=0, then release; advance to s0 and hold there.
      do_reset(3);
      step("rel_to_s0", 1'b0);
      step("hold_s0_a", 1'b0);
      step("hold_s0_b", 1'b0);

      // Reset again, then din=1 for 5 cycles: s0 s1 s0 s1 s0.
      do_reset(1);
      for (int i = 0; i < 5; i++) step("toggle", 1'b1);

      // Enter s1, hold it with din=0, then raise din for an immediate dout and s1 -> s0.
      step("to_s1", 1'b1);
      step("hold_s1_a", 1'b0);
      step("hold_s1_b", 1'b0);
      step("s1_exit", 1'b1);

      // Assert reset between edges while in s1 with din=1.
      step("to_s1_again", 1'b1);
      din = 1'b1;
      #1;
      check("s1_dout_before_rst", {2'b00, dout}, 3'b001);
      #2;
      do_reset(4);
      step("after_mid_rst", 1'b1);

      // The first 18 cycles after release with toggling din must reach every state.
      do_reset(1);
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      seen[2] = 1'b0;
      check_state("reach_start");
      for (int i = 0; i < 18; i++) step("reach", 1'(i % 3 != 0));
      check("reach_all", {seen[2], seen[1], seen[0]}, 3'b111);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            #($urandom_range(1, 3));
            do_reset($urandom_range(1, 3));
         end
         step("rand", 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters: none; state encoding is fixed to one-hot, 3 bits: idle=3'b001, s0=3'b010, s1=3'b100.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; forces state to idle immediately.
REQ-004 din  input  1  serial data/control input, sampled at rising clk.
REQ-005 dout  output  1  Mealy output; high during an s1->s0 transition cycle.
REQ-006 Port order SHALL be (clk, rst, din, dout) for positional instantiation.
REQ-007 Internal 3-bit registers/nets SHALL be named state (current) and next_state (combinational), with state constants named idle, s0, s1, so benches can probe them hierarchically.

Function
REQ-008 State register SHALL hold exactly one set bit at every rising clk edge, including during and after reset.
REQ-009 next_state SHALL be purely combinational from state and din.
REQ-010 Transition idle: next_state = s0 regardless of din.
REQ-011 Transition s0: din=1 -> s1; din=0 -> s0 (hold).
REQ-012 Transition s1: din=1 -> s0; din=0 -> s1 (hold).
REQ-013 Illegal/unreachable state value SHALL yield next_state = idle (default branch).
REQ-014 state SHALL load next_state on each rising clk while rst=0.
REQ-015 dout SHALL equal (state==s1) AND din, combinationally; equivalently dout=1 exactly when next_state==s0 and the current state is s1.
REQ-016 dout SHALL be 0 in idle and s0 for any din.
REQ-017 Constant din=1 from s0 SHALL toggle s0<->s1 every cycle, dout high every second cycle (each cycle spent in s1).
REQ-018 Constant din=0 SHALL hold s0 or s1 indefinitely with dout=0; from idle the FSM still advances to s0.

Reset
REQ-019 While rst=1, state SHALL be idle, asynchronously on assertion and on every clk edge during reset, for any reset length (≥1 cycle).
REQ-020 dout SHALL be 0 while rst=1 (follows from state=idle).
REQ-021 On the first rising clk after rst deasserts, state SHALL go idle->s0 independent of din.
REQ-022 Reset asserted mid-operation (in s0 or s1, any din) SHALL abort to idle with no dout glitch beyond the combinational settle.

Verification
REQ-023 rst=1 for 3 cycles, din=0 -> state=idle every edge, dout=0; after release: s0 next edge, then holds s0.
REQ-024 After reset release with din=1 for 5 cycles -> state sequence s0, s1, s0, s1, s0; dout=1 in each s1 cycle, 0 otherwise.
REQ-025 In s1, drop din to 0 for 2 cycles -> state stays s1, dout=0; raise din -> dout=1 immediately, state s0 next edge.
REQ-026 Assert rst asynchronously between edges while in s1 with din=1 -> state=idle and dout=0 before the next edge; hold rst 4 cycles, release -> s0 after first edge.
REQ-027 Every sampled cycle of all scenarios -> $onehot(state) true; idle, s0, s1 each reached within 18 cycles after reset release with din toggling.
